// File: rtl/k005297_seq_pkg.sv
// Shared types and constants for the k005297 bubble page-access sequencer.
package k005297_seq_pkg;

  localparam int unsigned ROT_W = 20;
  localparam logic [ROT_W-1:0] ROT20_PARK = 20'h7FFFF;

  typedef enum logic [2:0] {
    IDLE,
    SPINUP,
    WAIT,
    XFER,
    COAST
  } seq_state_t;

endpackage

// File: rtl/k005297_rot20_ring.sv
// 20-phase rotation ring with rotation counter; parks at bit19 whenever not running.
module k005297_rot20_ring
  import k005297_seq_pkg::*;
#(
  parameter int unsigned CYC_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  input  logic             run_i,
  input  logic             clear_i,
  output logic [ROT_W-1:0] rot_o,
  output logic [CYC_W-1:0] cnt_o,
  output logic             at_park_o,
  output logic             wrap_o
);

  logic [ROT_W-1:0] ring_q, ring_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;

  assign at_park_o = (ring_q == ROT20_PARK);
  assign wrap_o    = step_i & run_i & at_park_o;

  always_comb begin
    ring_d = ring_q;
    cnt_d  = cnt_q;
    if (step_i) begin
      ring_d = run_i ? {ring_q[ROT_W-2:0], ring_q[ROT_W-1]} : ROT20_PARK;
      if (clear_i) begin
        cnt_d = '0;
      end else if (wrap_o) begin
        cnt_d = cnt_q + CYC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ring_q <= ROT20_PARK;
      cnt_q  <= '0;
    end else begin
      ring_q <= ring_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rot_o = ring_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/k005297_access_seq.sv
// Page-access sequencer: spin-up, transfer window, coast; drives the rotation ring and
// the access-window gates seen by the trigger logic.
module k005297_access_seq
  import k005297_seq_pkg::*;
#(
  parameter int unsigned CYC_W       = 12,
  parameter int unsigned SPINUP_CYC  = 2,
  parameter int unsigned COAST_CYC   = 1,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             i_MCLK,
  input  logic             i_SYS_RST,
  input  logic             i_CLK2M_PCEN_n,
  input  logic             i_HALT,
  input  logic             i_CMD_REQ,
  input  logic             i_CMD_READ,
  output logic             o_CMD_ACK,
  input  logic             i_ACQ_START,
  input  logic             i_SWAP_START,
  input  logic             i_ACC_END,
  output logic [ROT_W-1:0] o_ROT20_n,
  output logic [CYC_W-1:0] o_CYCLECNTR,
  output logic             o_CYCLECNTR_LSB,
  output logic             o_UMODE_n,
  output logic             o_BDI_EN,
  output logic             o_FUNC_EN,
  output logic             o_XFER_EN,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic             o_ERR
);

  localparam logic [CYC_W-1:0] SPIN_V  = CYC_W'(SPINUP_CYC);
  localparam logic [CYC_W-1:0] COAST_V = CYC_W'(COAST_CYC);
  localparam logic [CYC_W-1:0] TMO_V   = CYC_W'(TIMEOUT_CYC);

  seq_state_t       state_q, state_d;
  logic             read_q, read_d, err_q, err_d, ack_q, done_q;
  logic [CYC_W-1:0] coast_q, coast_d, cnt;
  logic             step, busy, run, accept, coast_exit, at_park, wrap, win, timeout;

  assign step    = ~i_CLK2M_PCEN_n & ~i_HALT;
  assign busy    = (state_q != IDLE);
  assign timeout = (cnt >= TMO_V);
  assign accept  = step && (state_q == IDLE) && i_CMD_REQ;
  // The final coast wrap is replaced by parking, so the ring never leaves bit19 on exit.
  assign coast_exit = step && (state_q == COAST) && at_park && (coast_q == COAST_V);
  assign run        = busy & ~coast_exit;

  k005297_rot20_ring #(
    .CYC_W(CYC_W)
  ) u_ring (
    .clk_i    (i_MCLK),
    .rst_i    (i_SYS_RST),
    .step_i   (step),
    .run_i    (run),
    .clear_i  (accept),
    .rot_o    (o_ROT20_n),
    .cnt_o    (cnt),
    .at_park_o(at_park),
    .wrap_o   (wrap)
  );

  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    err_d   = err_q;
    coast_d = '0;
    if (state_q == COAST) begin
      coast_d = wrap ? coast_q + CYC_W'(1) : coast_q;
    end
    if (accept) begin
      state_d = SPINUP;
      read_d  = i_CMD_READ;
      err_d   = 1'b0;
    end else if (coast_exit) begin
      state_d = IDLE;
    end else if (step) begin
      case (state_q)
        SPINUP, WAIT, XFER: begin
          if (timeout) begin
            state_d = COAST;
            err_d   = 1'b1;
          end else if (state_q == SPINUP) begin
            if ((cnt == SPIN_V) && at_park) state_d = WAIT;
          end else if (state_q == WAIT) begin
            if (read_q ? i_ACQ_START : i_SWAP_START) begin
              state_d = XFER;
            end else if (i_ACC_END) begin
              state_d = COAST;
              err_d   = 1'b1;
            end
          end else if (i_ACC_END) begin
            state_d = COAST;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      err_q   <= 1'b0;
      coast_q <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      err_q   <= err_d;
      coast_q <= coast_d;
      ack_q   <= accept;
      done_q  <= coast_exit;
    end
  end

  assign win             = (state_q == WAIT) || (state_q == XFER);
  assign o_CYCLECNTR     = cnt;
  assign o_CYCLECNTR_LSB = cnt[0];
  assign o_UMODE_n       = ~win;
  assign o_BDI_EN        = win & read_q;
  assign o_FUNC_EN       = busy;
  assign o_XFER_EN       = (state_q == XFER);
  assign o_BUSY          = busy;
  assign o_CMD_ACK       = ack_q;
  assign o_DONE          = done_q;
  assign o_ERR           = err_q;

endmodule

// File: tb/tb_k005297_access_seq.sv
// Bench for k005297_access_seq: vector table, directed access sequences and random traffic
// checked each MCLK against a step-level reference model.
module tb_k005297_access_seq;

  localparam int unsigned SPIN   = 2;
  localparam int unsigned COASTN = 1;
  localparam int unsigned TMO    = 1024;

  localparam int MD_IDLE = 0, MD_SPIN = 1, MD_WAIT = 2, MD_XFER = 3, MD_COAST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, pcen_n = 1'b0, halt = 1'b0, req = 1'b0, rd = 1'b0;
  logic acq = 1'b0, swp = 1'b0, aend = 1'b0;
  logic [19:0] rot;
  logic [11:0] cnt;
  logic lsb, umode_n, bdi, func, xfer, busy, ack, done, err;

  k005297_access_seq #(
    .CYC_W(12), .SPINUP_CYC(SPIN), .COAST_CYC(COASTN), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_MCLK(clk), .i_SYS_RST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_HALT(halt),
    .i_CMD_REQ(req), .i_CMD_READ(rd), .o_CMD_ACK(ack),
    .i_ACQ_START(acq), .i_SWAP_START(swp), .i_ACC_END(aend),
    .o_ROT20_n(rot), .o_CYCLECNTR(cnt), .o_CYCLECNTR_LSB(lsb), .o_UMODE_n(umode_n),
    .o_BDI_EN(bdi), .o_FUNC_EN(func), .o_XFER_EN(xfer), .o_BUSY(busy),
    .o_DONE(done), .o_ERR(err)
  );

  int unsigned n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: low-bit position, rotations, and countdowns in steps to the next phase.
  int m_mode = MD_IDLE, m_pos = 19, m_left = 0;
  int unsigned m_rot = 0;
  bit m_read = 0, m_err = 0, m_ack = 0, m_done = 0;

  task automatic model_edge();
    int nxt;
    bit going;
    m_ack  = 0;
    m_done = 0;
    if (rst) begin
      m_mode = MD_IDLE; m_pos = 19; m_rot = 0; m_err = 0; m_read = 0; m_left = 0;
      return;
    end
    if (pcen_n || halt) return;
    nxt   = m_mode;
    going = (m_mode != MD_IDLE);
    if (m_mode == MD_IDLE) begin
      if (req) begin
        nxt = MD_SPIN; m_ack = 1; m_read = rd; m_err = 0; m_rot = 0;
        m_left = 20 * SPIN + 1;
      end
    end else if (m_mode == MD_COAST) begin
      m_left--;
      if (m_left == 0) begin nxt = MD_IDLE; m_done = 1; going = 0; end
    end else if (m_rot >= TMO) begin
      nxt = MD_COAST; m_err = 1;
    end else if (m_mode == MD_SPIN) begin
      m_left--;
      if (m_left == 0) nxt = MD_WAIT;
    end else if (m_mode == MD_WAIT) begin
      if ((m_read && acq) || (!m_read && swp)) nxt = MD_XFER;
      else if (aend) begin nxt = MD_COAST; m_err = 1; end
    end else if (aend) begin
      nxt = MD_COAST;
    end
    if (going) begin
      if (m_pos == 19) m_rot = (m_rot + 1) % 4096;
      m_pos = (m_pos + 1) % 20;
    end else begin
      m_pos = 19;
    end
    if (nxt == MD_COAST && m_mode != MD_COAST) m_left = (19 - m_pos) + 20 * COASTN + 1;
    m_mode = nxt;
  endtask

  function automatic logic [63:0] model_vec();
    logic [19:0] r;
    logic w;
    r = ~(20'd1 << m_pos);
    w = (m_mode == MD_WAIT) || (m_mode == MD_XFER);
    return {23'd0, r, 12'(m_rot), m_rot[0], ~w, w & m_read, m_mode != MD_IDLE,
            m_mode == MD_XFER, m_mode != MD_IDLE, m_ack, m_done, m_err};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {23'd0, rot, cnt, lsb, umode_n, bdi, func, xfer, busy, ack, done, err};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    pcen_n = 0; halt = 0; req = 0; rd = 0; acq = 0; swp = 0; aend = 0;
    rst = 1; tick(); rst = 0;
  endtask

  task automatic accept_req(input logic is_read);
    int n;
    rd = is_read; req = 1; n = 0;
    do begin tick(); n++; end while (!ack && n < 10);
    req = 0;
    check("accept", ack, 1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 2000) begin tick(); n++; end
    check(name, done, 1);
  endtask

  typedef struct {
    logic rst, pcen_n, halt, req, rd;
    logic [19:0] e_rot;
    logic [11:0] e_cnt;
    logic e_ack, e_busy, e_umode_n;
  } vec_t;
  vec_t tbl[12];

  int n_ack, first_x, last_x, bad, lat, clen;
  bit win_seen, coast_seen;
  logic [19:0] snap_rot;
  logic [11:0] snap_cnt, coast_cnt;
  logic coast_err;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h7FFFF, 12'd0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h7FFFF, 12'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'h7FFFF, 12'd0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 20'h7FFFF, 12'd0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h7FFFF, 12'd0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'h7FFFF, 12'd0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'hFFFFE, 12'd1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'hFFFFD, 12'd1, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 20'hFFFFD, 12'd1, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'hFFFFD, 12'd1, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 20'h7FFFF, 12'd0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h7FFFF, 12'd0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; pcen_n = tbl[i].pcen_n; halt = tbl[i].halt;
      req = tbl[i].req; rd = tbl[i].rd;
      tick();
      check($sformatf("vec%0d", i), {rot, cnt, ack, busy, umode_n},
            {tbl[i].e_rot, tbl[i].e_cnt, tbl[i].e_ack, tbl[i].e_busy, tbl[i].e_umode_n});
    end

    // Read access: acquire at rotation 5, end at rotation 9.
    do_reset();
    rd = 1; req = 1; n_ack = 0; first_x = -1; last_x = -1; bad = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      acq  = (m_mode == MD_WAIT) && (m_rot == 5) && (m_pos == 10);
      aend = (m_mode == MD_XFER) && (m_rot == 9) && (m_pos == 10);
      tick();
      if (ack) begin n_ack++; req = 0; end
      if (xfer) begin if (first_x < 0) first_x = int'(cnt); last_x = int'(cnt); end
      if (!umode_n && !bdi) bad++;
    end
    acq = 0; aend = 0;
    check("t1_done", done, 1);
    check("t1_ack_count", n_ack, 1);
    check("t1_xfer_first", first_x, 5);
    check("t1_xfer_last", last_x, 9);
    check("t1_bdi_in_window", bad, 0);
    check("t1_err", err, 0);
    check("t1_ring_parked", rot, 20'h7FFFF);

    // Write access: swap at rotation 4, ACQ_START toggling throughout.
    do_reset();
    rd = 0; req = 1; first_x = -1; last_x = -1; bad = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      acq  = (m_mode == MD_WAIT || m_mode == MD_XFER) && c[0];
      swp  = (m_mode == MD_WAIT) && (m_rot == 4) && (m_pos == 10);
      aend = (m_mode == MD_XFER) && (m_rot == 8) && (m_pos == 10);
      tick();
      if (ack) req = 0;
      if (xfer) begin if (first_x < 0) first_x = int'(cnt); last_x = int'(cnt); end
      if (bdi) bad++;
    end
    acq = 0; swp = 0; aend = 0;
    check("t2_done", done, 1);
    check("t2_bdi_never", bad, 0);
    check("t2_xfer_first", first_x, 4);
    check("t2_xfer_last", last_x, 8);
    check("t2_err", err, 0);

    // Timeout with no trigger flags.
    do_reset();
    accept_req(1'b1);
    win_seen = 0; coast_seen = 0; clen = 0; coast_cnt = '0; coast_err = 0;
    for (int c = 0; c < 25000 && !done; c++) begin
      tick();
      if (coast_seen) clen++;
      else if (win_seen && umode_n && busy) begin
        coast_seen = 1; coast_cnt = cnt; coast_err = err;
      end
      if (!umode_n) win_seen = 1;
    end
    check("t3_done", done, 1);
    check("t3_coast_cnt", coast_cnt, 12'd1024);
    check("t3_coast_err", coast_err, 1);
    check("t3_coast_len_in_range", (clen >= 20 && clen <= 41), 1);
    check("t3_err_sticky", err, 1);

    // Reset mid-transfer with the ring at bit 7.
    do_reset();
    accept_req(1'b1);
    for (int c = 0; c < 500 && !(xfer && m_pos == 7); c++) begin
      acq = (m_mode == MD_WAIT);
      tick();
    end
    acq = 0;
    check("t4_ring_bit7", rot, 20'hFFF7F);
    rst = 1; tick(); rst = 0;
    check("t4_reset_outputs",
          {rot, cnt, umode_n, bdi, func, xfer, busy, ack, done, err},
          {20'h7FFFF, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    // HALT for 50 MCLKs during spin-up.
    do_reset();
    accept_req(1'b1);
    lat = 0; bad = 0;
    repeat (10) begin tick(); lat++; end
    snap_rot = rot; snap_cnt = cnt;
    halt = 1;
    repeat (50) begin
      tick(); lat++;
      if (rot !== snap_rot || cnt !== snap_cnt) bad++;
    end
    halt = 0;
    for (int c = 0; c < 200 && umode_n; c++) begin tick(); lat++; end
    check("t5_frozen", bad, 0);
    check("t5_window_latency", lat, 20 * SPIN + 1 + 50);

    // Premature ACC_END in WAIT.
    aend = 1; tick(); aend = 0;
    check("t6_early_end", {err, umode_n, busy, xfer}, 4'b1110);
    wait_done("t6_early_done");

    // ACQ_START and ACC_END together: start wins, end taken next step.
    accept_req(1'b1);
    for (int c = 0; c < 200 && umode_n; c++) tick();
    acq = 1; aend = 1; tick(); acq = 0;
    check("t6_start_wins", {xfer, err}, 2'b10);
    tick(); aend = 0;
    check("t6_end_next", {xfer, umode_n, busy, err}, 4'b0110);
    wait_done("t6_both_done");

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst    = ($urandom_range(0, 499) == 0);
      pcen_n = $urandom_range(0, 1);
      halt   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) req = ~req;
      rd   = $urandom_range(0, 1);
      acq  = ($urandom_range(0, 59) == 0);
      swp  = ($urandom_range(0, 59) == 0);
      aend = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
